sonic_vc_rx_fifo_p0_adapter_fifo: RTL and testbench
===================================================

// Module: sonic_vc_rx_fifo_p0_adapter_fifo
// PURPOSE
// - Receive-side counterpart of the TX adapter FIFO: store-and-forward packet buffer between the
//   RX datapath (no backpressure) and the VC receive logic (ready/valid sink).
// - Only complete packets are released downstream. Packets that overflow the buffer or are
//   malformed are discarded whole and counted.
// PARAMETERS
// - DEPTH       16   words of storage; must equal 2**ADDR_WIDTH
// - DATA_WIDTH  133  word width; bit 132 = sop, bit 131 = eop, bits 130:0 opaque payload
// - ADDR_WIDTH  4    memory address width; pointers are ADDR_WIDTH+1 bits (wrap bit)
// PORTS
// - clk         in   1             rising-edge clock
// - reset       in   1             asynchronous, active-high reset
// - in_valid    in   1             word present on in_data; source cannot be stalled
// - in_data     in   DATA_WIDTH    incoming word incl. sop/eop flags
// - out_ready   in   1             downstream accepts out_data this cycle
// - out_valid   out  1             out_data holds a committed word
// - out_data    out  DATA_WIDTH    registered head-of-FIFO word
// - fill_level  out  ADDR_WIDTH+1  committed words held (commit_ptr - rd_ptr), 0..DEPTH
// - drop_pulse  out  1             one-cycle pulse when a packet is discarded for overflow
// - err_pulse   out  1             one-cycle pulse when a framing error discards data
// - drop_count  out  16            saturating count of overflow drops
// - err_count   out  16            saturating count of framing errors
// BEHAVIOUR
// - Reset: wr_ptr = commit_ptr = rd_ptr = 0, state IDLE, out_valid = 0, out_data = 0,
//   pulses 0, counters 0. Reset mid-packet discards the partial packet silently (not counted).
// - Pointers: wr_ptr (speculative write), commit_ptr (end of last good packet), rd_ptr.
//   space_full = (wr_ptr - rd_ptr == DEPTH), using rd_ptr before this cycle's pop.
// - Write: accepted word stored at mem[wr_ptr[ADDR_WIDTH-1:0]], wr_ptr += 1.
// - FSM states IDLE, PKT, DROP; evaluated only when in_valid = 1:
//   IDLE, sop, !full: write; eop ? commit_ptr <= wr_ptr+1 (stay IDLE) : -> PKT.
//   IDLE, !sop: framing error, word discarded; eop ? stay IDLE : -> DROP.
//   PKT, !sop, !full: write; on eop commit_ptr <= wr_ptr+1, -> IDLE.
//   PKT, sop (missing eop): framing error; wr_ptr rewinds to commit_ptr; new packet restarts at
//     commit_ptr this cycle (same rules as IDLE+sop).
//   IDLE/PKT, full: overflow; word discarded, wr_ptr <= commit_ptr, drop_pulse; eop ? IDLE : DROP.
//   DROP: discard all words; on eop -> IDLE; sop in DROP starts a new packet as in IDLE.
// - Packets longer than DEPTH words are always dropped. A drop or error never disturbs words
//   already committed.
// - Read: pop = out_valid & out_ready; rd_ptr += pop. Registered prefetch:
//   out_data <= mem[pop ? rd_ptr+1 : rd_ptr]; out_valid <= (commit_ptr != rd_ptr + pop).
// - Latency: eop accepted at edge k -> commit at edge k -> out_valid high after edge k+1.
// - Simultaneous write and pop are both honoured; full check is conservative (pre-pop).
// - out_valid/out_data hold stable while out_ready = 0.
// - Counters saturate at 16'hFFFF; pulses last exactly one cycle per event.
// - fill_level excludes uncommitted words of the packet in progress.
// TESTING
// - 3-word packet (sop..eop, payload 1,2,3), out_ready=1 -> out_valid 1 cycle after eop edge,
//   words 1,2,3 on consecutive cycles, fill_level returns to 0.
// - out_ready=0, two 8-word packets -> fill_level 16; third packet sop arrives -> drop_pulse,
//   drop_count=1; out_ready=1 then drains exactly 16 words in order.
// - 20-word packet into empty FIFO -> dropped at word 17, drop_count=1, nothing delivered; next
//   2-word packet delivered intact.
// - sop,word,sop,eop (missing eop) -> err_count=1, only second 2-word packet delivered.
// - words without sop then eop in IDLE -> err_count=1, fill_level stays 0.
// - reset asserted mid-packet with 4 committed words -> out_valid=0, fill_level=0 immediately;
//   next packet after release delivered correctly.

Source files
------------

// File: rtl/sonic_vc_rx_fifo_p0_adapter_fifo_if.sv
// Handshake bundle between the RX datapath, the RX adapter FIFO and the VC receive logic.
// master drives the packet stream and out_ready; slave is the FIFO itself.
interface sonic_vc_rx_fifo_p0_adapter_fifo_if #(
    parameter int unsigned DATA_WIDTH = 133,
    parameter int unsigned ADDR_WIDTH = 4
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_ready;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic [ADDR_WIDTH:0]   fill_level;
    logic                  drop_pulse;
    logic                  err_pulse;
    logic [15:0]           drop_count;
    logic [15:0]           err_count;

    modport master (
        output in_valid, in_data, out_ready,
        input  out_valid, out_data, fill_level, drop_pulse, err_pulse, drop_count, err_count
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output out_valid, out_data, fill_level, drop_pulse, err_pulse, drop_count, err_count
    );
endinterface

// File: rtl/sonic_vc_rx_fifo_p0_adapter_fifo.sv
// Store-and-forward RX packet buffer: only whole packets are released downstream; overflowing
// or malformed packets are discarded whole and counted.
module sonic_vc_rx_fifo_p0_adapter_fifo #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned DATA_WIDTH = 133,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input logic clk,
    input logic reset,
    sonic_vc_rx_fifo_p0_adapter_fifo_if.slave bus
);
    localparam int unsigned PW = ADDR_WIDTH + 1;
    typedef logic [PW-1:0] ptr_t;
    typedef enum logic [1:0] {StIdle, StPkt, StDrop} state_e;

    state_e state_q, state_d;
    ptr_t   wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d, rd_ptr_q, rd_ptr_d, base_ptr;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  out_valid_q, drop_pulse_q, err_pulse_q;
    logic [15:0]           drop_count_q, err_count_q;
    logic sop, eop, in_pkt, claims, full, wr_en, overflow, framing_err, pop;

    assign sop    = bus.in_data[DATA_WIDTH-1];
    assign eop    = bus.in_data[DATA_WIDTH-2];
    assign in_pkt = (state_q == StPkt);
    // A sop always opens a packet; a non-sop word only belongs to one already open.
    assign claims = bus.in_valid & (sop | in_pkt);
    // A sop while a packet is open abandons it, so the new packet starts at commit_ptr.
    assign base_ptr    = (in_pkt & sop) ? commit_ptr_q : wr_ptr_q;
    assign full        = ((base_ptr - rd_ptr_q) == ptr_t'(DEPTH));
    assign wr_en       = claims & ~full;
    assign overflow    = claims & full;
    assign framing_err = bus.in_valid & (in_pkt ? sop : ((state_q == StIdle) & ~sop));
    assign pop         = out_valid_q & bus.out_ready;
    assign rd_ptr_d    = rd_ptr_q + {{ADDR_WIDTH{1'b0}}, pop};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.in_valid) begin
            if (eop)                         state_d = StIdle;
            else if ((sop | in_pkt) & ~full) state_d = StPkt;
            else                             state_d = StDrop;
        end
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        if (overflow) begin
            wr_ptr_d = commit_ptr_q;
        end else if (wr_en) begin
            wr_ptr_d = base_ptr + ptr_t'(1);
            if (eop) commit_ptr_d = base_ptr + ptr_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[base_ptr[ADDR_WIDTH-1:0]] <= bus.in_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            drop_pulse_q <= 1'b0;
            err_pulse_q  <= 1'b0;
            drop_count_q <= '0;
            err_count_q  <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            // Prefetch the next head; a packet committed this edge shows up one edge later.
            out_valid_q  <= (commit_ptr_q != rd_ptr_d);
            out_data_q   <= mem[rd_ptr_d[ADDR_WIDTH-1:0]];
            drop_pulse_q <= overflow;
            err_pulse_q  <= framing_err;
            if (overflow && (drop_count_q != 16'hFFFF))   drop_count_q <= drop_count_q + 16'd1;
            if (framing_err && (err_count_q != 16'hFFFF)) err_count_q  <= err_count_q + 16'd1;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.fill_level = commit_ptr_q - rd_ptr_q;
    assign bus.drop_pulse = drop_pulse_q;
    assign bus.err_pulse  = err_pulse_q;
    assign bus.drop_count = drop_count_q;
    assign bus.err_count  = err_count_q;
endmodule

// File: tb/tb_sonic_vc_rx_fifo_p0_adapter_fifo.sv
// Bench for the RX adapter FIFO: directed scenarios plus random traffic, all checked every cycle
// against a packet-level queue model.
module tb_sonic_vc_rx_fifo_p0_adapter_fifo;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   popped = 0;

    always #5 clk = ~clk;

    sonic_vc_rx_fifo_p0_adapter_fifo_if #(.DATA_WIDTH(133), .ADDR_WIDTH(4)) bus ();

    sonic_vc_rx_fifo_p0_adapter_fifo #(
        .DEPTH(16),
        .DATA_WIDTH(133),
        .ADDR_WIDTH(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // Model: committed words, words of the open packet, and the expected output register.
    logic [132:0] fifo[$];
    logic [132:0] cur[$];
    bit           active, dropping, m_valid, m_dp, m_ep;
    logic [132:0] m_data;
    int           m_drop, m_err;

    function automatic logic [132:0] mk(input bit s, input bit e, input logic [130:0] p);
        return {s, e, p};
    endfunction

    function automatic logic [130:0] rnd_payload();
        logic [159:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return t[130:0];
    endfunction

    task automatic chk(input string tag, input logic [132:0] obs, input logic [132:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        fifo.delete();
        cur.delete();
        active = 0; dropping = 0; m_valid = 0; m_dp = 0; m_ep = 0;
        m_drop = 0; m_err = 0;
    endtask

    task automatic model_word(input logic [132:0] w, input int sz0);
        bit s, e;
        s = w[132];
        e = w[131];
        if (s) begin
            if (active) begin m_ep = 1; if (m_err < 65535) m_err++; end
            cur.delete();
            active = 0;
            if (sz0 >= 16) begin
                m_dp = 1; if (m_drop < 65535) m_drop++;
                dropping = !e;
            end else begin
                dropping = 0;
                cur.push_back(w);
                if (e) begin foreach (cur[i]) fifo.push_back(cur[i]); cur.delete(); end
                else active = 1;
            end
        end else if (active) begin
            if (sz0 + cur.size() >= 16) begin
                m_dp = 1; if (m_drop < 65535) m_drop++;
                cur.delete();
                active = 0;
                dropping = !e;
            end else begin
                cur.push_back(w);
                if (e) begin
                    foreach (cur[i]) fifo.push_back(cur[i]);
                    cur.delete();
                    active = 0;
                end
            end
        end else if (dropping) begin
            if (e) dropping = 0;
        end else begin
            m_ep = 1; if (m_err < 65535) m_err++;
            dropping = !e;
        end
    endtask

    // One clock: drive inputs, advance the model across the edge, compare 1ns later.
    task automatic step(input bit v, input logic [132:0] w, input bit rdy);
        int sz0;
        bit obs_pop;
        bus.in_valid  = v;
        bus.in_data   = w;
        bus.out_ready = rdy;
        obs_pop = bus.out_valid & rdy;
        @(posedge clk);
        if (obs_pop) popped++;
        sz0 = fifo.size();
        if (m_valid && rdy) fifo.delete(0);
        m_valid = (fifo.size() > 0);
        if (m_valid) m_data = fifo[0];
        m_dp = 0;
        m_ep = 0;
        if (v) model_word(w, sz0);
        #1;
        chk("out_valid", bus.out_valid, m_valid);
        if (m_valid) chk("out_data", bus.out_data, m_data);
        chk("fill_level", bus.fill_level, fifo.size());
        chk("drop_pulse", bus.drop_pulse, m_dp);
        chk("err_pulse", bus.err_pulse, m_ep);
        chk("drop_count", bus.drop_count, m_drop);
        chk("err_count", bus.err_count, m_err);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, '0, rdy);
    endtask

    task automatic send_pkt(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b1, mk(i == 0, i == n - 1, rnd_payload()), rdy);
    endtask

    initial begin
        bit v, s, e, r;
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_fill", bus.fill_level, 0);
        chk("rst_pulses", {bus.drop_pulse, bus.err_pulse}, 0);
        chk("rst_counts", {bus.drop_count, bus.err_count}, 0);
        reset = 1'b0;

        // 3-word packet, payload 1,2,3
        step(1'b1, mk(1, 0, 131'd1), 1'b1);
        step(1'b1, mk(0, 0, 131'd2), 1'b1);
        step(1'b1, mk(0, 1, 131'd3), 1'b1);
        chk("t1_not_yet_valid", bus.out_valid, 0);
        idle(1, 1'b1);
        chk("t1_w1", bus.out_data, mk(1, 0, 131'd1));
        idle(1, 1'b1);
        chk("t1_w2", bus.out_data, mk(0, 0, 131'd2));
        idle(1, 1'b1);
        chk("t1_w3", bus.out_data, mk(0, 1, 131'd3));
        idle(1, 1'b1);
        chk("t1_empty", bus.fill_level, 0);

        // Fill to 16 with two 8-word packets, third packet overflows
        send_pkt(8, 1'b0);
        send_pkt(8, 1'b0);
        chk("t2_fill16", bus.fill_level, 16);
        send_pkt(5, 1'b0);
        chk("t2_drop1", bus.drop_count, 1);
        popped = 0;
        idle(20, 1'b1);
        chk("t2_drain16", popped, 16);
        chk("t2_empty", bus.fill_level, 0);

        // Oversized packet then a good 2-word packet
        popped = 0;
        send_pkt(20, 1'b1);
        chk("t3_drop2", bus.drop_count, 2);
        chk("t3_none", popped, 0);
        send_pkt(2, 1'b1);
        idle(5, 1'b1);
        chk("t3_deliver2", popped, 2);

        // Missing eop: sop,word,sop,eop
        popped = 0;
        step(1'b1, mk(1, 0, rnd_payload()), 1'b1);
        step(1'b1, mk(0, 0, rnd_payload()), 1'b1);
        step(1'b1, mk(1, 0, rnd_payload()), 1'b1);
        step(1'b1, mk(0, 1, rnd_payload()), 1'b1);
        idle(5, 1'b1);
        chk("t4_err1", bus.err_count, 1);
        chk("t4_deliver2", popped, 2);

        // Words with no sop in idle
        step(1'b1, mk(0, 0, rnd_payload()), 1'b1);
        step(1'b1, mk(0, 0, rnd_payload()), 1'b1);
        step(1'b1, mk(0, 1, rnd_payload()), 1'b1);
        idle(2, 1'b1);
        chk("t5_err2", bus.err_count, 2);
        chk("t5_fill0", bus.fill_level, 0);

        // Reset mid-packet with 4 committed words
        send_pkt(4, 1'b0);
        idle(2, 1'b0);
        chk("t6_fill4", bus.fill_level, 4);
        step(1'b1, mk(1, 0, rnd_payload()), 1'b0);
        step(1'b1, mk(0, 0, rnd_payload()), 1'b0);
        #1;
        reset = 1'b1;
        #1;
        chk("t6_rst_valid", bus.out_valid, 0);
        chk("t6_rst_fill", bus.fill_level, 0);
        chk("t6_rst_counts", {bus.drop_count, bus.err_count}, 0);
        model_clear();
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        popped = 0;
        send_pkt(3, 1'b1);
        idle(6, 1'b1);
        chk("t6_deliver3", popped, 3);

        // Random traffic: a backpressured phase, then a mostly-draining phase
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 4) == 0);
            e = ($urandom_range(0, 4) == 0);
            r = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            step(v, mk(s, e, rnd_payload()), r);
        end
        idle(20, 1'b1);
        chk("final_fill0", bus.fill_level, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
